mem_ram_clr: RTL
================

Name: mem_ram_clr

Overview:
- Parametrised single-port RAM; successor to the fixed 32K x 16 memory.
- Keeps the asynchronous read port `spo` and the synchronous write port.
- Adds:
  - a registered read port with a valid flag;
  - a hardware clear sequencer that fills every word with a constant, after reset or on request;
  - a busy/done handshake for that sequencer.
- Sits between the datapath/CPU and program/data storage. Software can zero memory without a per-word loop.

Parameters:
- DATA_W, 16, word width in bits (>=1).
- ADDR_W, 15, address width; DEPTH = 2**ADDR_W words.
- CLEAR_VAL, 0, DATA_W-bit value written by the clear sequencer.
- CLEAR_ON_RESET, 1, if 1 the clear sweep starts automatically when rst_n deasserts.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- a, input, ADDR_W, user address for read and write.
- d, input, DATA_W, user write data.
- we, input, 1, user write enable.
- re, input, 1, registered-read request.
- clr_start, input, 1, one-cycle pulse that requests a clear sweep.
- spo, output, DATA_W, asynchronous read data = memory[a].
- rdata, output, DATA_W, registered read data.
- rvalid, output, 1, rdata valid (one-cycle pulse per accepted re).
- busy, output, 1, clear sweep in progress.
- done, output, 1, one-cycle pulse on the cycle after the last clear write.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - state = CLEAR if CLEAR_ON_RESET else IDLE;
  - clear counter = 0;
  - rdata = 0, rvalid = 0, done = 0;
  - busy = CLEAR_ON_RESET.
  - Memory contents are not reset by rst_n; only the sweep initialises them.
- FSM states are IDLE and CLEAR.
- IDLE:
  - If we=1, memory[a] <= d at the clock edge.
  - If re=1, then at the next edge rdata <= memory[a] (value before any same-edge write, i.e. read-first) and rvalid <= 1. Otherwise rvalid <= 0.
  - If clr_start=1, go to CLEAR with counter=0. A we/re sampled on that same edge is still performed.
- CLEAR:
  - Each cycle writes memory[counter] <= CLEAR_VAL and increments counter; one word per cycle.
  - When counter = DEPTH-1, the write happens, then state -> IDLE and done <= 1 for one cycle.
  - busy = 1 for exactly DEPTH cycles.
  - User we and re are ignored in CLEAR: no write, rvalid stays 0.
  - clr_start is ignored in CLEAR; the sweep does not restart.
- spo:
  - Purely combinational from a and the array in every state, including CLEAR.
  - Reflects a write on the edge it is committed.
- Counter:
  - ADDR_W bits; the terminal compare is against all-ones, so no wrap-around is observed.
- Reset mid-sweep:
  - Aborts the sweep immediately.
  - If CLEAR_ON_RESET=1, the sweep restarts from address 0 after release; otherwise the FSM stays IDLE and partially cleared contents are kept.
- Latency:
  - registered read = 1 cycle;
  - write = committed at the sampling edge;
  - full clear = DEPTH cycles, with done on cycle DEPTH+1 after entry.
- busy and done are registered outputs; there are no combinational paths from inputs to them.
- The array must be inferable as distributed or block RAM; the registered read path maps to the BRAM output register.

Test Plan:
1. ADDR_W=4, CLEAR_VAL=16'hA5A5, CLEAR_ON_RESET=1; release rst_n:
   - busy=1 for 16 cycles, then done=1 for 1 cycle, busy=0;
   - spo reads 16'hA5A5 at a=0..15.
2. IDLE, write 16'h1234 to a=3:
   - next cycle spo=16'h1234 combinationally;
   - re=1 at a=3 gives rdata=16'h1234, rvalid=1 one cycle later, then rvalid=0.
3. Same edge we=1, re=1, a=5, old word 16'h0000, d=16'hBEEF:
   - rdata=16'h0000 (read-first);
   - spo=16'hBEEF after the edge.
4. clr_start pulse, then we=1 a=2 d=16'hFFFF and re=1 during the sweep:
   - memory[2]=16'hA5A5 after done;
   - rvalid never asserts while busy;
   - a second clr_start mid-sweep does not extend busy beyond 16 cycles.
5. Assert rst_n=0 at sweep address 7, hold 2 cycles, release:
   - outputs go to reset values asynchronously, without waiting for clk;
   - sweep restarts at 0 and busy lasts 16 full cycles.
6. CLEAR_ON_RESET=0, reset release:
   - busy=0, done never pulses;
   - a written value survives a subsequent rst_n pulse (contents not reset).

Source files
------------

// File: rtl/mem_ram_clr.sv
// Parametrised single-port RAM with asynchronous read (spo), a registered read port and a
// hardware clear sequencer that fills every word with CLEAR_VAL after reset or on request.
module mem_ram_clr #(
  parameter int unsigned       DATA_W         = 16,
  parameter int unsigned       ADDR_W         = 15,
  parameter logic [DATA_W-1:0] CLEAR_VAL      = '0,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] d,
  input  logic              we,
  input  logic              re,
  input  logic              clr_start,
  output logic [DATA_W-1:0] spo,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;
  localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_en;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RESET_STATE;
      cnt_q    <= '0;
      busy_q   <= CLEAR_ON_RESET;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // busy is registered from the next state so it rises on the entry edge and falls with the last write.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = a;
    mem_wdata = d;
    rd_en     = 1'b0;
    rvalid_d  = 1'b0;
    done_d    = 1'b0;
    busy_d    = (state_d == CLEAR);
    unique case (state_q)
      IDLE: begin
        mem_we   = we;
        rd_en    = re;
        rvalid_d = re;
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = CLEAR_VAL;
        done_d    = (cnt_q == '1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_addr] <= mem_wdata;
  end

  // Sampling the array with <= on the write edge gives read-first behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rdata_q <= '0;
    else if (rd_en) rdata_q <= mem_q[a];
  end

  assign spo    = mem_q[a];
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
